// File: rtl/partial_boundary_stitch.sv
// Snapshot FIFO between a partial module and its consumer, with held replay of lifted outputs.
// Optional drop counter enabled by defining PARTIAL_STITCH_DROP_COUNT_EN.
module partial_boundary_stitch #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                       CLK,
    input  logic                       ASYNCRESET,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       out_ready,
    output logic                       lifted_input0,
    output logic                       lifted_input1,
    output logic [$clog2(DEPTH+1)-1:0] count
`ifdef PARTIAL_STITCH_DROP_COUNT_EN
    ,
    output logic [7:0]                 drop_count
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_li0;
    logic             r_li1;

    logic w_push;
    logic w_pop;

    // Reset gates in_ready directly so it drops at once and returns on the first cycle after release.
    assign in_ready  = !ASYNCRESET && (r_count < DEPTH_C) && !flush && (r_state != FLUSH);
    assign out_valid = (r_count != '0) && (r_state == RUN);
    assign out_data  = r_mem[r_rd_ptr];

    assign w_push = in_valid && in_ready;
    assign w_pop  = out_valid && out_ready;

    assign count         = r_count;
    assign lifted_input0 = r_li0;
    assign lifted_input1 = r_li1;

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            r_state  <= IDLE;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_li0    <= 1'b0;
            r_li1    <= 1'b0;
        end else if (flush) begin
            r_state  <= FLUSH;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                r_li0    <= out_data[0];
                r_li1    <= out_data[1];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            case (r_state)
                IDLE: begin
                    if (w_push) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (w_pop && !w_push && (r_count == CNT_W'(1))) begin
                        r_state <= IDLE;
                    end
                end
                FLUSH: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef PARTIAL_STITCH_DROP_COUNT_EN
    logic [7:0] r_drop_count;

    // Counts refused offers; survives flush, only reset clears it.
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            r_drop_count <= 8'd0;
        end else if (in_valid && !in_ready && (r_drop_count != 8'hFF)) begin
            r_drop_count <= r_drop_count + 8'd1;
        end
    end

    assign drop_count = r_drop_count;
`endif

endmodule
